icache_sa: RTL and testbench
============================

# icache_sa

Parametrised set-associative instruction cache between the fetch stage and instruction memory. Replaces the single-word, fully associative FIFO fetch cache with multi-word lines, configurable sets and ways, per-set round-robin replacement, burst line refill and a whole-cache invalidate for `fence.i`. Each fetch request returns one 32-bit instruction word.

## Interface
- `ADDR_W`, 32: byte address width.
- `SETS`, 8: number of sets; power of two, at least 2.
- `WAYS`, 4: associativity; power of two, at least 1.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.
---
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  fetch request. Sampled only in IDLE.
- `cpu_addr`  in  ADDR_W  fetch byte address. Bits [1:0] are ignored. Registered on acceptance.
- `cpu_ready`  out  1  one-cycle pulse; `cpu_rdata` is valid in the same cycle.
- `cpu_rdata`  out  32  fetched instruction word.
- `flush`  in  1  invalidate-all pulse.
- `flush_busy`  out  1  high from `flush` sampling until the invalidate completes.
- `mem_req`  out  1  line refill request. Held through the whole burst.
- `mem_addr`  out  ADDR_W  line-aligned refill address. Stable while `mem_req` is high.
- `mem_valid`  in  1  one refill beat is present.
- `mem_rdata`  in  32  beat data. Beats arrive in ascending word order.

## Operation
- Address split:
  - offset = log2(LINE_WORDS)+2 LSBs.
  - index = next log2(SETS) bits.
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_WORDS data words.
- Storage per set: round-robin victim pointer, log2(WAYS) bits; 0 bits when WAYS=1.
- States:
  - IDLE:
    - Pending or new `flush` goes to FLUSH; this has priority over `cpu_req`.
    - Otherwise `cpu_req` registers the address and goes to LOOKUP.
  - LOOKUP: tag compare across all ways of the indexed set.
    - Hit (exactly one way) drives `cpu_ready`=1 and `cpu_rdata`=word[offset], then goes to IDLE.
    - Miss goes to REFILL.
  - REFILL:
    - `mem_req`=1, `mem_addr`={tag,index,0}. Beat counter starts at 0.
    - Each `mem_valid` writes `mem_rdata` into the victim way at word = counter, then increments the counter.
    - On the last beat: set valid and tag, advance the set's victim pointer (wrapping WAYS-1 to 0), drop `mem_req` the next cycle, and go to LOOKUP. That lookup is a guaranteed hit.
  - FLUSH: clears every valid bit and every victim pointer in one cycle, then goes to IDLE.
- The victim is always the pointer's way, even if an invalid way exists in the set.
- `mem_valid` outside REFILL is ignored.

## Timing
- Reset values:
  - outputs: `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_addr`=0, `flush_busy`=0.
  - internal: all valid bits 0, victim pointers 0, state IDLE.
  - Data and tag arrays need not be reset.
- Hit latency: request accepted at cycle N, `cpu_ready` at N+1. Earliest next acceptance is N+2.
- Miss latency: `mem_req` rises at N+2. With k-th beat arriving at cycle B_k, `cpu_ready` comes at B_last+2.
- `flush` arriving in LOOKUP or REFILL is latched and `flush_busy` rises next cycle. The in-flight request still completes and returns its data. The invalidate then runs before the next acceptance.
- `flush` in IDLE: FLUSH next cycle; `flush_busy` falls the cycle after FLUSH.
- `flush` together with `cpu_req` in IDLE: the request is not accepted. The requester keeps `cpu_req` high.
- `rst` during REFILL: `mem_req`=0 the next cycle. The partial line is never marked valid. Late beats are ignored.
- `cpu_addr` may change after acceptance without effect.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt`, 32 bits each, wrapping modulo 2^32, cleared only by `rst`.
  - `hit_cnt` increments on each LOOKUP hit that is not the post-refill lookup.
  - `miss_cnt` increments on each LOOKUP miss.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold miss: after reset, fetch 0x0000_0104 with memory returning 0xA0+i on beat i.
  - `mem_addr`=0x0000_0100 and 4 beats.
  - `cpu_rdata`=0xA1 at B_last+2.
  - Fetch 0x0000_010C next: hit, `cpu_rdata`=0xA3 one cycle after acceptance, no `mem_req`.
- Set conflict: defaults, fill set 0 with lines 0x000, 0x080, 0x100, 0x180, then fetch 0x200.
  - Evicts way 0 (line 0x000).
  - Refetch 0x000 misses and evicts way 1.
  - 0x100 still hits.
- Flush during refill: assert `flush` on the 2nd beat.
  - The response still returns the correct word.
  - `flush_busy` falls after FLUSH.
  - Refetching the same address misses.
- Reset mid-refill: assert `rst` after beat 1, then 3 stray `mem_valid` pulses.
  - `mem_req`=0 the next cycle and no `cpu_ready`.
  - The address misses afterwards.
- Back-to-back hits with `cpu_req` held high on a hot line: `cpu_ready` every 2nd cycle with correct words.
- With `ICACHE_STATS_EN`: run the cold-miss sequence plus 3 hits; expect `miss_cnt`=1 and `hit_cnt`=3.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction cache: round-robin victims, burst line refill, whole-cache invalidate.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_sa #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              flush,
    output logic              flush_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_REFILL = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:2]   addr_q, addr_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic                refilled_q, refilled_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_W-1:0]    ptr_q   [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [31:0]         data_q  [SETS][WAYS][LINE_WORDS];

    logic [ADDR_W-1:2]   lk_w_s;
    logic [OFF_W-1:0]    lk_off_s;
    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic [WAYS-1:0]     match_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic                hit_s;
    logic [31:0]         hit_word_s;
    logic [WAY_W-1:0]    vict_s;
    logic                fill_we_s, fill_last_s, clear_s;
    logic                unused_addr_s;

    // In IDLE the incoming address is looked up so a hit can be registered at acceptance.
    assign lk_w_s        = (state_q == S_IDLE) ? cpu_addr[ADDR_W-1:2] : addr_q;
    assign lk_off_s      = lk_w_s[OFF_W+1:2];
    assign lk_idx_s      = lk_w_s[OFF_W+2 +: IDX_W];
    assign lk_tag_s      = lk_w_s[ADDR_W-1 -: TAG_W];
    assign vict_s        = ptr_q[lk_idx_s];
    assign hit_s         = |match_s;
    assign hit_word_s    = data_q[lk_idx_s][hit_way_s][lk_off_s];
    assign unused_addr_s = ^cpu_addr[1:0];

    // Tag compare across the indexed set; at most one way can match.
    always_comb begin
        match_s   = '0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_s[w] = valid_q[lk_idx_s][w] && (tag_q[lk_idx_s][w] == lk_tag_s);
            hit_way_s  = hit_way_s | (match_s[w] ? WAY_W'(w) : '0);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        refilled_d  = refilled_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        busy_d      = busy_q | flush;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fill_we_s   = 1'b0;
        fill_last_s = 1'b0;
        clear_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush || busy_q) begin
                    state_d = S_FLUSH;
                end else if (cpu_req) begin
                    state_d    = S_LOOKUP;
                    addr_d     = cpu_addr[ADDR_W-1:2];
                    refilled_d = 1'b0;
                    ready_d    = hit_s;
                    rdata_d    = hit_s ? hit_word_s : rdata_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    state_d = S_IDLE;
                    // A first-pass hit was already answered at acceptance.
                    ready_d = refilled_q;
                    rdata_d = refilled_q ? hit_word_s : rdata_q;
                end else begin
                    state_d    = S_REFILL;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                end
            end
            S_REFILL: begin
                if (mem_valid) begin
                    fill_we_s = 1'b1;
                    beat_d    = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        fill_last_s = 1'b1;
                        mem_req_d   = 1'b0;
                        refilled_d  = 1'b1;
                        state_d     = S_LOOKUP;
                    end else begin
                        state_d = S_REFILL;
                    end
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_FLUSH: begin
                clear_s = 1'b1;
                busy_d  = flush;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            refilled_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            refilled_q <= refilled_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Valid bits and victim pointers; a line becomes valid only on its last beat.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (fill_last_s) begin
            valid_q[lk_idx_s][vict_s] <= 1'b1;
            ptr_q[lk_idx_s]           <= (WAYS > 1) ? vict_s + WAY_W'(1) : '0;
        end else begin
            ptr_q[lk_idx_s] <= ptr_q[lk_idx_s];
        end
    end

    // Tag and data arrays, written without reset.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_q[lk_idx_s][vict_s][beat_q] <= mem_rdata;
        end
        if (fill_last_s) begin
            tag_q[lk_idx_s][vict_s] <= lk_tag_s;
        end
    end

    assign cpu_ready  = ready_q;
    assign cpu_rdata  = rdata_q;
    assign flush_busy = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        first_look_s;

    assign first_look_s = (state_q == S_LOOKUP) && !refilled_q;

    // Post-refill lookups are not counted as hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_q + ((first_look_s && hit_s) ? 32'd1 : 32'd0);
            miss_cnt_q <= miss_cnt_q + ((first_look_s && !hit_s) ? 32'd1 : 32'd0);
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: cold miss, hits, conflict eviction, flush and reset
// interactions, plus the hit/miss counters when ICACHE_STATS_EN is defined.
module tb_icache_sa;
    logic        clk = 1'b0;
    logic        rst, cpu_req, flush, mem_valid;
    logic [31:0] cpu_addr, mem_rdata, mem_addr, cpu_rdata;
    logic        cpu_ready, flush_busy, mem_req;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    int total = 0;
    int bad   = 0;

    icache_sa dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .flush      (flush),
        .flush_busy (flush_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string name);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Miss with full refill; beat i returns base+i. fl_beat >= 0 raises flush on that beat.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] base,
                              input int fl_beat, input string name);
        logic [31:0] line;
        logic [31:0] exp_word;
        line     = addr & 32'hFFFF_FFF0;
        exp_word = base + ((addr >> 2) & 32'd3);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        tick();
        cpu_req  = 1'b0;
        cpu_addr = 32'hDEAD_BEE0;
        check(32'(cpu_ready), 32'd0, {name, " lookup ready"});
        check(32'(mem_req), 32'd0, {name, " lookup mem_req"});
        tick();
        check(mem_addr, line, {name, " mem_addr"});
        for (int i = 0; i < 4; i++) begin
            check(32'(mem_req), 32'd1, {name, " mem_req held"});
            if (fl_beat >= 0 && i == fl_beat + 1) begin
                check(32'(flush_busy), 32'd1, {name, " flush_busy rise"});
            end
            mem_valid = 1'b1;
            mem_rdata = base + 32'(i);
            flush     = (i == fl_beat);
            tick();
        end
        mem_valid = 1'b0;
        flush     = 1'b0;
        check(32'(mem_req), 32'd0, {name, " mem_req drop"});
        check(32'(cpu_ready), 32'd0, {name, " early ready"});
        tick();
        check(32'(cpu_ready), 32'd1, {name, " ready"});
        check(cpu_rdata, exp_word, {name, " rdata"});
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp, input string name);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        tick();
        cpu_req = 1'b0;
        check(32'(cpu_ready), 32'd1, {name, " ready"});
        check(cpu_rdata, exp, {name, " rdata"});
        check(32'(mem_req), 32'd0, {name, " no mem_req"});
        tick();
        check(32'(cpu_ready), 32'd0, {name, " ready low"});
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'd0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        check(32'(cpu_ready), 32'd0, "rst cpu_ready");
        check(cpu_rdata, 32'd0, "rst cpu_rdata");
        check(32'(mem_req), 32'd0, "rst mem_req");
        check(mem_addr, 32'd0, "rst mem_addr");
        check(32'(flush_busy), 32'd0, "rst flush_busy");
        rst = 1'b0;
        tick();

        fetch_miss(32'h0000_0104, 32'h0000_00A0, -1, "cold");
        fetch_hit(32'h0000_010C, 32'h0000_00A3, "hit10c");
        fetch_hit(32'h0000_0100, 32'h0000_00A0, "hit100");
        fetch_hit(32'h0000_0108, 32'h0000_00A2, "hit108");
`ifdef ICACHE_STATS_EN
        check(miss_cnt, 32'd1, "stats miss_cnt");
        check(hit_cnt, 32'd3, "stats hit_cnt");
`endif

        // cpu_req held high: one response every second cycle
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0100;
        tick();
        check(32'(cpu_ready), 32'd1, "b2b ready0");
        check(cpu_rdata, 32'h0000_00A0, "b2b rdata0");
        cpu_addr = 32'h0000_0104;
        tick();
        check(32'(cpu_ready), 32'd0, "b2b gap0");
        tick();
        check(32'(cpu_ready), 32'd1, "b2b ready1");
        check(cpu_rdata, 32'h0000_00A1, "b2b rdata1");
        cpu_addr = 32'h0000_010C;
        tick();
        check(32'(cpu_ready), 32'd0, "b2b gap1");
        tick();
        check(32'(cpu_ready), 32'd1, "b2b ready2");
        check(cpu_rdata, 32'h0000_00A3, "b2b rdata2");
        cpu_req = 1'b0;
        tick();
        check(32'(cpu_ready), 32'd0, "b2b idle");

        // flush from IDLE
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check(32'(flush_busy), 32'd1, "idle flush busy");
        tick();
        check(32'(flush_busy), 32'd0, "idle flush done");
        fetch_miss(32'h0000_0104, 32'h0000_00B0, -1, "postflush");

        // set conflict on set 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_miss(32'h0000_0000, 32'h5500_0000, -1, "fill000");
        fetch_miss(32'h0000_0080, 32'h5508_0000, -1, "fill080");
        fetch_miss(32'h0000_0100, 32'h5510_0000, -1, "fill100");
        fetch_miss(32'h0000_0180, 32'h5518_0000, -1, "fill180");
        fetch_miss(32'h0000_0204, 32'h5520_0000, -1, "fill200");
        fetch_hit(32'h0000_0084, 32'h5508_0001, "keep080");
        fetch_hit(32'h0000_0188, 32'h5518_0002, "keep180");
        fetch_hit(32'h0000_010C, 32'h5510_0003, "keep100");
        fetch_miss(32'h0000_0000, 32'h6600_0000, -1, "refetch000");
        fetch_hit(32'h0000_0100, 32'h5510_0000, "still100");
        fetch_hit(32'h0000_0200, 32'h5520_0000, "still200");
        fetch_miss(32'h0000_0080, 32'h6608_0000, -1, "evicted080");

        // flush raised on the second refill beat
        fetch_miss(32'h0000_0308, 32'h7700_0000, 1, "flushrefill");
        check(32'(flush_busy), 32'd1, "pend busy");
        tick();
        check(32'(flush_busy), 32'd1, "pend flushing");
        tick();
        check(32'(flush_busy), 32'd0, "pend done");
        fetch_miss(32'h0000_0308, 32'h7800_0000, -1, "refetch308");

        // flush together with cpu_req: request waits until after the invalidate
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0308;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check(32'(cpu_ready), 32'd0, "flushreq ready");
        check(32'(flush_busy), 32'd1, "flushreq busy");
        tick();
        check(32'(flush_busy), 32'd0, "flushreq done");
        check(32'(cpu_ready), 32'd0, "flushreq no ready");
        fetch_miss(32'h0000_0308, 32'h7900_0000, -1, "flushreq");

        // reset in the middle of a refill, then stray beats
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0404;
        tick();
        cpu_req = 1'b0;
        tick();
        check(32'(mem_req), 32'd1, "midrst mem_req");
        mem_valid = 1'b1;
        mem_rdata = 32'h9900_0000;
        tick();
        mem_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check(32'(mem_req), 32'd0, "midrst mem_req low");
        check(32'(cpu_ready), 32'd0, "midrst ready");
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_rdata = 32'hBAD0_0000 + 32'(i);
            tick();
            mem_valid = 1'b0;
            check(32'(cpu_ready), 32'd0, "stray ready");
            check(32'(mem_req), 32'd0, "stray mem_req");
            tick();
        end
        fetch_miss(32'h0000_0404, 32'h9A00_0000, -1, "afterrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
